regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_merge.sv | 28 ++
 rtl/regfile.sv | 99 +++++++++
 tb/tb_regfile.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile block.
// Optional feature macro used by the top: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Address width for a given register count; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_merge.sv
// Next-value computation for one register: full write, upper-half write, or hold.
// Shared by the register write path and the same-edge read forwarding path so
// both always agree on what a register will contain after the edge.
module regfile_merge
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    input  logic             writeu,
    output logic [WIDTH-1:0] new_val
);

    localparam int HALF = WIDTH / 2;

    // Full write wins over the upper-half write; the upper half takes din's low half.
    always_comb begin
        new_val = old_val;
        if (write) begin
            new_val = din;
        end else if (writeu) begin
            new_val = {din[HALF-1:0], old_val[HALF-1:0]};
        end
    end

endmodule

// File: rtl/regfile.sv
// Two-read / one-write register file with registered read data.
// Optional build macro REGFILE_BYPASS_EN: when defined, a read of the address
// being written on the same edge returns the post-write value; otherwise it
// returns the pre-write value. Register 0 can be hardwired to zero (ZERO_REG).
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              din,
    input  logic [addr_width(DEPTH)-1:0]  waddr,
    input  logic                          write,
    input  logic                          writeu,
    input  logic                          read,
    input  logic [addr_width(DEPTH)-1:0]  raddr_a,
    input  logic [addr_width(DEPTH)-1:0]  raddr_b,
    output logic [WIDTH-1:0]              dout_a,
    output logic [WIDTH-1:0]              dout_b,
    output logic                          dout_valid
);

    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] wr_next;
    logic             wr_en;
    logic             waddr_zero;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Value the addressed register will hold after this edge.
    regfile_merge #(
        .WIDTH (WIDTH)
    ) u_merge (
        .old_val (regs[waddr]),
        .din     (din),
        .write   (write),
        .writeu  (writeu),
        .new_val (wr_next)
    );

    // A write lands unless it targets a hardwired-zero register 0.
    always_comb begin
        waddr_zero = (waddr == AW'(0));
        wr_en      = (write || writeu) && !((ZERO_REG != 0) && waddr_zero);
    end

    // Register array update; reset clears every entry and drops any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wr_next;
        end
    end

    // Read-port data selection, with optional forwarding of the write in flight.
    always_comb begin
        rd_a = regs[raddr_a];
        rd_b = regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (raddr_a == waddr)) begin
            rd_a = wr_next;
        end
        if (wr_en && (raddr_b == waddr)) begin
            rd_b = wr_next;
        end
`endif
        // Hardwired zero overrides everything, including forwarding.
        if ((ZERO_REG != 0) && (raddr_a == AW'(0))) begin
            rd_a = '0;
        end
        if ((ZERO_REG != 0) && (raddr_b == AW'(0))) begin
            rd_b = '0;
        end
    end

    // Registered read outputs; data holds between reads, valid pulses per read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a     <= '0;
            dout_b     <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= read;
            if (read) begin
                dout_a <= rd_a;
                dout_b <= rd_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: two instances (ZERO_REG=0 and ZERO_REG=1) driven by the
// same stimulus, checked against a reference model through a scoreboard queue.
module tb_regfile;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int H  = W / 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, write, writeu, read;
    logic [W-1:0]  din;
    logic [AW-1:0] waddr, raddr_a, raddr_b;
    logic [W-1:0]  dout_a, dout_b, zout_a, zout_b;
    logic          dout_valid, zout_valid;

    always #5 clk = ~clk;

    regfile #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst(rst), .din(din), .waddr(waddr), .write(write),
        .writeu(writeu), .read(read), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .dout_a(dout_a), .dout_b(dout_b), .dout_valid(dout_valid)
    );

    regfile #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .rst(rst), .din(din), .waddr(waddr), .write(write),
        .writeu(writeu), .read(read), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .dout_a(zout_a), .dout_b(zout_b), .dout_valid(zout_valid)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] za;
        logic [W-1:0] zb;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mdl  [D];
    logic [W-1:0] mdlz [D];
    exp_t         held;
    int           tests_run    = 0;
    int           tests_failed = 0;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                           input logic w, input logic wu);
        if (w)  return d;
        if (wu) return {d[H-1:0], old[H-1:0]};
        return old;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic w, input logic wu,
                        input logic rd, input logic [AW-1:0] wa, input logic [W-1:0] d,
                        input logic [AW-1:0] a, input logic [AW-1:0] b);
        exp_t         e;
        logic [W-1:0] nv, nvz;
        logic         we, wez, vexp;
        rst = r; write = w; writeu = wu; read = rd;
        waddr = wa; din = d; raddr_a = a; raddr_b = b;
        we   = w || wu;
        wez  = we && (wa != '0);
        nv   = merge(mdl[wa], d, w, wu);
        nvz  = merge(mdlz[wa], d, w, wu);
        e.a  = (BYP && we && a == wa) ? nv : mdl[a];
        e.b  = (BYP && we && b == wa) ? nv : mdl[b];
        e.za = (a == '0) ? '0 : ((BYP && wez && a == wa) ? nvz : mdlz[a]);
        e.zb = (b == '0) ? '0 : ((BYP && wez && b == wa) ? nvz : mdlz[b]);
        if (r) begin
            for (int i = 0; i < D; i++) begin
                mdl[i]  = '0;
                mdlz[i] = '0;
            end
        end else begin
            if (rd) sb.push_back(e);
            if (we) mdl[wa] = nv;
            if (wez) mdlz[wa] = nvz;
        end
        vexp = rd && !r;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, W'(dout_valid), W'(vexp));
        check({tag, ".zvalid"}, W'(zout_valid), W'(vexp));
        if (r) begin
            held = '0;
        end else if (vexp) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            end else begin
                held = sb.pop_front();
            end
        end
        check({tag, ".a"}, dout_a, held.a);
        check({tag, ".b"}, dout_b, held.b);
        check({tag, ".za"}, zout_a, held.za);
        check({tag, ".zb"}, zout_b, held.zb);
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; writeu = 1'b0; read = 1'b0;
        din = '0; waddr = '0; raddr_a = '0; raddr_b = '0;
        held = '0;
        for (int i = 0; i < D; i++) begin
            mdl[i]  = '0;
            mdlz[i] = '0;
        end

        // reset beats a simultaneous write and read
        step("rst_prio", 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd1);
        step("rst_read", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd3, 3'd5);
        step("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        // plain write then read, same address on both ports
        step("wr2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0F0F, 3'd0, 3'd0);
        step("rd2", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd2, 3'd2);
        // upper-half write
        step("wu2", 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0003, 3'd0, 3'd0);
        step("rd2u", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd2, 3'd1);
        // write has priority over writeu
        step("wwu4", 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 16'h1234, 3'd0, 3'd0);
        step("rd4", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd4, 3'd2);
        step("hold4", 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h7777, 3'd6, 3'd6);
        // same-edge write and read
        step("wr6", 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 16'h5555, 3'd0, 3'd0);
        step("byp6", 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd6);
        step("rd6", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd6, 3'd4);
        step("bypu6", 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 16'h00BB, 3'd6, 3'd2);
        step("rd6u", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd6, 3'd6);
        // register 0: writable in one instance, hardwired zero in the other
        step("wr0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'hFFFF, 3'd0, 3'd0);
        step("rd0", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd0, 3'd4);
        step("byp0", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0012, 3'd0, 3'd0);
        step("rd0b", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd6, 3'd0);

        for (int i = 0; i < 60; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), AW'($urandom), W'($urandom),
                 AW'($urandom), AW'($urandom));
        end

        // reset in the middle of a read stream
        step("stream1", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd2, 3'd4);
        step("stream_rst", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd2, 3'd4);
        step("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd2, 3'd6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
